// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of N_SRC fallthrough FIFOs into one registered word stream; `FIFO_ARB_BURST_EN` enables multi-word grants.
// Latency: fifo_rd and the load are in the same cycle, and out_valid follows one cycle later; a grant costs one IDLE cycle.
// Backpressure: out_valid && !out_ready holds the word and suppresses all reads until accepted.
module fifo_rr_arbiter #(
    parameter int N_SRC     = 4,
    parameter int WIDTH     = 30,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     en,
    input  logic [N_SRC*WIDTH-1:0]   fifo_data,
    input  logic [N_SRC-1:0]         fifo_empty,
    output logic [N_SRC-1:0]         fifo_rd,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N_SRC)-1:0] out_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);
    localparam int SW = $clog2(N_SRC);

    typedef enum logic {S_IDLE, S_XFER} state_t;
    state_t r_state, w_state_nxt;

    logic [SW-1:0]    r_grant, r_last_grant, w_pick, w_idx;
    logic             w_any, w_load, w_last, w_done;
    logic [WIDTH-1:0] w_src_words [N_SRC];
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_src;
    logic             r_out_valid;

    for (genvar g = 0; g < N_SRC; g++) begin : g_words
        assign w_src_words[g] = fifo_data[g*WIDTH +: WIDTH];
    end
    assign w_word = w_src_words[r_grant];
    assign w_any  = ~&fifo_empty;

    // Scan from the farthest offset down so the nearest non-empty source after last_grant wins.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            w_idx = SW'((int'(r_last_grant) + k) % N_SRC);
            if (!fifo_empty[w_idx]) w_pick = w_idx;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int             BCW      = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] LAST_CNT = BCW'(MAX_BURST - 1);
    logic [BCW-1:0] r_burst_cnt;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)                r_burst_cnt <= '0;
        else if (r_state == S_IDLE) r_burst_cnt <= '0;
        else if (w_load)           r_burst_cnt <= r_burst_cnt + BCW'(1);
    end

    assign w_last = (r_burst_cnt == LAST_CNT);
`else
    // Every grant is a single word; MAX_BURST is at least 1, so this is constant high.
    assign w_last = (MAX_BURST >= 1);
`endif

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        fifo_rd     = '0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && w_any) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                w_load = !fifo_empty[r_grant] && (!r_out_valid || out_ready);
                w_done = fifo_empty[r_grant] || (w_load && w_last);
                if (w_load) fifo_rd[r_grant] = 1'b1;
                if (w_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_grant      <= '0;
            r_last_grant <= SW'(N_SRC - 1);
            r_out_data   <= '0;
            r_out_src    <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && en && w_any) r_grant <= w_pick;
            if (w_done) r_last_grant <= r_grant;
            if (w_load) begin
                r_out_data  <= w_word;
                r_out_src   <= r_grant;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == S_XFER);
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: FIFO queues and a transaction-level arbiter model checked every cycle,
// plus literal delivery-order expectations for the directed scenarios.
module tb_fifo_rr_arbiter;
    localparam int N     = 4;
    localparam int W     = 30;
    localparam int MB    = 4;
    localparam int SW    = 2;
    localparam int DEPTH = 256;
`ifdef FIFO_ARB_BURST_EN
    localparam int BURST = MB;
    int seq_a [12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2};
    int seq_b [6]  = '{3, 3, 1, 1, 2, 2};
`else
    localparam int BURST = 1;
    int seq_a [6]  = '{0, 1, 0, 1, 0, 1};
    int seq_b [6]  = '{3, 1, 2, 3, 1, 2};
`endif

    logic           clk, res_n, en, out_ready, out_valid, busy;
    logic [N*W-1:0] fifo_data;
    logic [N-1:0]   fifo_empty, fifo_rd;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;

    fifo_rr_arbiter #(.N_SRC(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .res_n      (res_n),
        .en         (en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source FIFO contents: word = {source, absolute push index}.
    logic [W-1:0] mem [N][DEPTH];
    int wp [N];
    int rp [N];
    int next_seq [N];
    int n_cmp, n_err;

    // Arbiter model: current grant (or none), words moved in it, last finished grant, output register.
    bit           m_busy, m_ov, m_load;
    int           m_src, m_cnt, m_last, m_os;
    logic [W-1:0] m_od;

    bit           s_ov, s_busy;
    logic [W-1:0] s_od;
    logic [N-1:0] s_rd;
    int           dlv_src [$];
    logic [W-1:0] dlv_dat [$];
    int           exp_q [$];

    function automatic logic [W-1:0] word_of(input int s, input int idx);
        return W'((s << 20) | (idx & 32'h000F_FFFF));
    endfunction

    function automatic int occ(input int s);
        return wp[s] - rp[s];
    endfunction

    function automatic int total();
        int t = 0;
        for (int s = 0; s < N; s++) t += occ(s);
        return t;
    endfunction

    function automatic int pick();
        for (int k = 1; k <= N; k++)
            if (occ((m_last + k) % N) > 0) return (m_last + k) % N;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            mem[s][wp[s] % DEPTH] = word_of(s, wp[s]);
            wp[s]++;
        end
    endtask

    task automatic show_fifos();
        logic [N-1:0]   e;
        logic [N*W-1:0] d;
        e = '0;
        d = '0;
        for (int s = 0; s < N; s++) begin
            e = e | (N'(occ(s) == 0) << s);
            d = d | ((N*W)'(mem[s][rp[s] % DEPTH]) << (s * W));
        end
        fifo_empty = e;
        fifo_data  = d;
    endtask

    task automatic model_reset();
        m_busy = 0; m_ov = 0; m_load = 0;
        m_src = 0; m_cnt = 0; m_last = N - 1; m_os = 0; m_od = '0;
        for (int s = 0; s < N; s++) next_seq[s] = rp[s];
    endtask

    task automatic cycle();
        logic [N-1:0] exp_rd;
        bit           was_empty;
        show_fifos();
        @(negedge clk);
        m_load = m_busy && occ(m_src) > 0 && (!m_ov || out_ready);
        exp_rd = m_load ? (N'(1) << m_src) : '0;
        s_ov = out_valid; s_od = out_data; s_rd = fifo_rd; s_busy = busy;
        chk("fifo_rd", 64'(fifo_rd), 64'(exp_rd));
        chk("rd_on_empty", 64'(fifo_rd & fifo_empty), 64'(0));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            chk("out_data", 64'(out_data), 64'(m_od));
            chk("out_src", 64'(out_src), 64'(m_os));
        end
        if (res_n && out_valid && out_ready) begin
            dlv_src.push_back(int'(out_src));
            dlv_dat.push_back(out_data);
            chk("order", 64'(out_data), 64'(word_of(int'(out_src), next_seq[out_src])));
            next_seq[out_src]++;
        end
        @(posedge clk);
        if (res_n) begin
            if (!m_busy) begin
                if (m_ov && out_ready) m_ov = 0;
                if (en && pick() >= 0) begin
                    m_src = pick(); m_cnt = 0; m_busy = 1;
                end
            end else begin
                was_empty = (occ(m_src) == 0);
                if (m_load) begin
                    m_od = mem[m_src][rp[m_src] % DEPTH];
                    m_os = m_src; m_ov = 1; m_cnt++;
                end else if (m_ov && out_ready) begin
                    m_ov = 0;
                end
                if (was_empty || (m_load && m_cnt == BURST)) begin
                    m_busy = 0; m_last = m_src;
                end
            end
        end
        for (int s = 0; s < N; s++)
            if (((s_rd >> s) & N'(1)) != '0 && occ(s) > 0) rp[s]++;
        #1;
    endtask

    task automatic drain(input int budget);
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (total() == 0 && !s_ov && !s_busy) break;
        end
        chk("drain_left", 64'(total()), 64'(0));
        chk("drain_out_valid", 64'(out_valid), 64'(0));
    endtask

    task automatic check_seq(input string name);
        chk(name, 64'(dlv_src.size()), 64'(exp_q.size()));
        foreach (exp_q[i])
            chk(name, 64'(i < dlv_src.size() ? dlv_src[i] : -1), 64'(exp_q[i]));
    endtask

    initial begin
        int base;
        n_cmp = 0; n_err = 0;
        res_n = 1'b0; en = 1'b0; out_ready = 1'b0;
        for (int s = 0; s < N; s++) begin wp[s] = 0; rp[s] = 0; end
        model_reset();
        show_fifos();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_fifo_rd", 64'(fifo_rd), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        res_n = 1'b1; en = 1'b1; out_ready = 1'b1;

        // All empty after release: nothing may happen.
        repeat (20) cycle();
        chk("idle_busy", 64'(busy), 64'(0));

        // First grants after reset and round-robin order.
        dlv_src.delete(); dlv_dat.delete();
`ifdef FIFO_ARB_BURST_EN
        push(0, 6); push(2, 6);
`else
        push(0, 3); push(1, 3);
`endif
        drain(100);
        exp_q.delete();
        foreach (seq_a[i]) exp_q.push_back(seq_a[i]);
        check_seq("rr_order");

        // Output stall: word held, no reads, nothing lost.
        dlv_src.delete(); dlv_dat.delete();
        out_ready = 1'b0;
        base = wp[1];
        push(1, 3);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_ov) break;
        end
        chk("stall_first_load", 64'(s_ov), 64'(1));
        repeat (5) begin
            cycle();
            chk("stall_data", 64'(s_od), 64'(word_of(1, base)));
            chk("stall_rd1", 64'(s_rd[1]), 64'(0));
        end
        drain(40);
        for (int i = 0; i < 3; i++)
            chk("stall_word", 64'(i < dlv_dat.size() ? dlv_dat[i] : 'x), 64'(word_of(1, base + i)));

        // Source 3 runs dry mid-grant; next grant wraps to source 1.
        dlv_src.delete(); dlv_dat.delete();
        push(3, 2);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_busy) break;
        end
        chk("g3_busy", 64'(s_busy), 64'(1));
        push(1, 2); push(2, 2);
        drain(100);
        exp_q.delete();
        foreach (seq_b[i]) exp_q.push_back(seq_b[i]);
        check_seq("empty_release");

        // Asynchronous reset with a held, unaccepted word.
        out_ready = 1'b0;
        push(1, 4);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_ov) break;
        end
        push(0, 3);
        show_fifos();
        chk("pre_arst_valid", 64'(out_valid), 64'(1));
        #2;
        res_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_fifo_rd", 64'(fifo_rd), 64'(0));
        model_reset();
        cycle();
        cycle();
        res_n = 1'b1;
        dlv_src.delete(); dlv_dat.delete();
        drain(100);
        chk("arst_first_src", 64'(dlv_src.size() > 0 ? dlv_src[0] : -1), 64'(0));
        chk("arst_count", 64'(dlv_src.size()), 64'(6));

        // Randomized traffic, enable and backpressure.
        dlv_src.delete(); dlv_dat.delete();
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < N; s++)
                if ($urandom_range(0, 3) == 0 && occ(s) < 200) push(s, 1);
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
